// File: rtl/dest_reg_tracker_pkg.sv
// Shared types and constants for tracking destination registers through the EX, MEM and WB stages.
// Holds the stage record, the forwarding-select encodings and the producer-match helper.
package dest_reg_tracker_pkg;

    localparam int ADDR_W = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              is_load;
    } stage_t;

    // r0 is hardwired to zero in the register file, so it never needs forwarding.
    function automatic logic producer_match(input stage_t s, input logic [ADDR_W-1:0] r,
                                            input logic used);
        return s.valid && s.we && (s.rd == r) && (r != '0) && used;
    endfunction

endpackage

// File: rtl/dest_reg_tracker_fwd_select.sv
// Selects the forwarding source for one ALU operand, with the nearest producer taking priority.
// Latency: purely combinational. Backpressure: none; the load-hazard flag feeds the stall logic in the parent.
module fwd_select
    import dest_reg_tracker_pkg::*;
(
    input  logic [ADDR_W-1:0] src,
    input  logic              used,
    input  stage_t            ex,
    input  stage_t            mem,
    input  stage_t            wb,
    output logic [1:0]        fwd,
    output logic              load_hazard
);

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    assign hit_ex  = producer_match(ex,  src, used);
    assign hit_mem = producer_match(mem, src, used);
    assign hit_wb  = producer_match(wb,  src, used);

    always_comb begin
        fwd = FWD_RF;
        if (hit_ex) begin
            fwd = FWD_EX;
        end else if (hit_mem) begin
            fwd = FWD_MEM;
        end else if (hit_wb) begin
            fwd = FWD_WB;
        end
    end

    // A load in EX has no data yet, so it can only be bridged by a bubble.
    assign load_hazard = hit_ex & ex.is_load;

endmodule

// File: rtl/dest_reg_tracker.sv
// Tracks in-flight destination registers and drives the load-use stall, the operand forwarding selects and a stall counter.
// Latency: STALL and FWD are combinational from the stage records. Backpressure: STALL holds decode and inserts a bubble into EX.
module dest_reg_tracker #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ID_VALID,
    input  logic [ADDR_W-1:0] ID_RD,
    input  logic              ID_WE,
    input  logic              ID_IS_LOAD,
    input  logic [ADDR_W-1:0] RS1,
    input  logic [ADDR_W-1:0] RS2,
    input  logic              RS1_USED,
    input  logic              RS2_USED,
    input  logic              FLUSH,
    output logic              STALL,
    output logic [1:0]        FWD_A,
    output logic [1:0]        FWD_B,
    output logic [ADDR_W-1:0] WB_RD,
    output logic              WB_WE,
    output logic [CNT_W-1:0]  STALL_CNT
);

    import dest_reg_tracker_pkg::*;

    stage_t            ex_q;
    stage_t            mem_q;
    stage_t            wb_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              haz_a;
    logic              haz_b;

    fwd_select u_fwd_a (
        .src         (RS1),
        .used        (RS1_USED),
        .ex          (ex_q),
        .mem         (mem_q),
        .wb          (wb_q),
        .fwd         (FWD_A),
        .load_hazard (haz_a)
    );

    fwd_select u_fwd_b (
        .src         (RS2),
        .used        (RS2_USED),
        .ex          (ex_q),
        .mem         (mem_q),
        .wb          (wb_q),
        .fwd         (FWD_B),
        .load_hazard (haz_b)
    );

    assign STALL = haz_a | haz_b;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            // A flushed or stalled decode slot enters EX as a bubble; older stages are unaffected.
            if (STALL || FLUSH || !ID_VALID) begin
                ex_q <= '0;
            end else begin
                ex_q <= '{valid: 1'b1, rd: ID_RD, we: ID_WE, is_load: ID_IS_LOAD};
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q <= '0;
        end else if (STALL && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign WB_RD     = wb_q.rd;
    assign WB_WE     = wb_q.valid & wb_q.we;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Scoreboard bench: directed vectors push hand-computed expectations; a negedge monitor pops and compares.
// A second instance with a 4-bit counter shares the stimulus to exercise counter saturation.
module tb_dest_reg_tracker;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ID_VALID;
    logic [4:0] ID_RD;
    logic       ID_WE;
    logic       ID_IS_LOAD;
    logic [4:0] RS1;
    logic [4:0] RS2;
    logic       RS1_USED;
    logic       RS2_USED;
    logic       FLUSH;

    logic        stall;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [15:0] cnt16;

    logic        stall_s;
    logic [1:0]  fwd_a_s;
    logic [1:0]  fwd_b_s;
    logic [4:0]  wb_rd_s;
    logic        wb_we_s;
    logic [3:0]  cnt4;

    always #5 CLK = ~CLK;

    dest_reg_tracker #(.ADDR_W(5), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_RD(ID_RD), .ID_WE(ID_WE),
        .ID_IS_LOAD(ID_IS_LOAD), .RS1(RS1), .RS2(RS2), .RS1_USED(RS1_USED),
        .RS2_USED(RS2_USED), .FLUSH(FLUSH), .STALL(stall), .FWD_A(fwd_a), .FWD_B(fwd_b),
        .WB_RD(wb_rd), .WB_WE(wb_we), .STALL_CNT(cnt16)
    );

    dest_reg_tracker #(.ADDR_W(5), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_RD(ID_RD), .ID_WE(ID_WE),
        .ID_IS_LOAD(ID_IS_LOAD), .RS1(RS1), .RS2(RS2), .RS1_USED(RS1_USED),
        .RS2_USED(RS2_USED), .FLUSH(FLUSH), .STALL(stall_s), .FWD_A(fwd_a_s), .FWD_B(fwd_b_s),
        .WB_RD(wb_rd_s), .WB_WE(wb_we_s), .STALL_CNT(cnt4)
    );

    typedef struct {
        logic        stall;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [4:0]  wrd;
        logic        wwe;
        logic [15:0] c16;
        logic [3:0]  c4;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    int          checks   = 0;
    int          failures = 0;
    int unsigned m16      = 0;
    int unsigned m4       = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("stall",      16'(stall),   16'(me.stall));
            chk("fwd_a",      16'(fwd_a),   16'(me.fa));
            chk("fwd_b",      16'(fwd_b),   16'(me.fb));
            chk("wb_rd",      16'(wb_rd),   16'(me.wrd));
            chk("wb_we",      16'(wb_we),   16'(me.wwe));
            chk("stall_cnt",  cnt16,        me.c16);
            chk("sat_stall",  16'(stall_s), 16'(me.stall));
            chk("sat_cnt",    16'(cnt4),    16'(me.c4));
        end
    end

    // One cycle: drive inputs just after the edge and queue the outputs expected before the next edge.
    task automatic cyc(input logic rst, input logic v, input logic [4:0] rd, input logic we,
                       input logic ld, input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                       input logic u2, input logic fl, input logic es, input logic [1:0] ea,
                       input logic [1:0] eb, input logic [4:0] erd, input logic ewe);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET = rst; ID_VALID = v; ID_RD = rd; ID_WE = we; ID_IS_LOAD = ld;
        RS1 = s1; RS1_USED = u1; RS2 = s2; RS2_USED = u2; FLUSH = fl;
        if (rst) begin
            m16 = 0;
            m4  = 0;
        end
        e = '{es, ea, eb, erd, ewe, m16[15:0], m4[3:0]};
        q.push_back(e);
        if (es && !rst) begin
            if (m16 < 65535) m16++;
            if (m4 < 15) m4++;
        end
    endtask

    initial begin
        RESET = 1'b1; ID_VALID = 1'b0; ID_RD = '0; ID_WE = 1'b0; ID_IS_LOAD = 1'b0;
        RS1 = '0; RS2 = '0; RS1_USED = 1'b0; RS2_USED = 1'b0; FLUSH = 1'b0;

        //  rst v  rd we ld  s1 u1 s2 u2 fl   stall fa fb wrd wwe
        cyc(1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        // ALU back-to-back, then the producer walks MEM and WB
        cyc(0, 1, 3, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  3, 1, 0, 0, 0,  0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  3, 1, 0, 0, 0,  0, 2, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  3, 1, 0, 0, 0,  0, 3, 0, 3, 1);
        cyc(0, 0, 0, 0, 0,  3, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        // Load-use: one stall, then forward from MEM
        cyc(0, 1, 7, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 1, 8, 1, 0,  0, 0, 7, 1, 0,  1, 0, 1, 0, 0);
        cyc(0, 1, 8, 1, 0,  0, 0, 7, 1, 0,  0, 0, 2, 0, 0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 7, 1);
        cyc(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 8, 1);
        // r0 never matches; unused operand never matches
        cyc(0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 1, 5, 1, 0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  0, 1, 5, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  0, 0, 5, 1, 0,  0, 0, 2, 0, 1);
        cyc(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 5, 1);
        // Nearest producer wins; flush kills only the decode slot
        cyc(0, 1, 4, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 1, 4, 1, 0,  4, 1, 0, 0, 0,  0, 1, 0, 0, 0);
        cyc(0, 1, 9, 1, 0,  4, 1, 0, 0, 1,  0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  9, 1, 4, 1, 0,  0, 0, 2, 4, 1);
        cyc(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 4, 1);
        // Flush and stall together: bubble enters EX, stall still counted
        cyc(0, 1, 6, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 1, 10, 1, 0, 6, 1, 0, 0, 1,  1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  6, 1, 0, 0, 0,  0, 2, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  6, 1, 0, 0, 0,  0, 3, 0, 6, 1);
        // Chain of loads each consuming the previous one: stall every other cycle, 20 stalls
        for (int i = 0; i <= 40; i++) begin
            cyc(0, 1, 7, 1, 1,  0, 0, 7, 1, 0,
                (i % 2 == 1), 0, (i == 0) ? 2'd0 : ((i % 2 == 1) ? 2'd1 : 2'd2),
                ((i % 2 == 1) && i >= 3) ? 5'd7 : 5'd0, ((i % 2 == 1) && i >= 3));
        end
        cyc(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 7, 1);
        // Fill all three stages, then reset mid-stream
        cyc(0, 1, 1, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 1, 2, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 7, 1);
        cyc(0, 1, 3, 1, 0,  1, 1, 2, 1, 0,  0, 2, 1, 0, 0);
        cyc(0, 1, 4, 1, 0,  3, 1, 2, 1, 0,  0, 1, 2, 1, 1);
        cyc(1, 1, 5, 1, 0,  3, 1, 2, 1, 0,  0, 0, 0, 0, 0);
        cyc(1, 1, 5, 1, 0,  3, 1, 2, 1, 0,  0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 1, 3, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0,  3, 1, 0, 0, 0,  0, 1, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
